// File: rtl/sram_read_streamer_if.sv
// SRAM read-bus and byte-stream signals for sram_read_streamer.
// master = streamer side, slave = SRAM + stream consumer side.
interface sram_read_streamer_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_db;
  logic              ram_ce_n;
  logic              ram_oe_n;
  logic              ram_we_n;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_adr, ram_ce_n, ram_oe_n, ram_we_n, out_data, out_valid,
    input  mem_db, out_ready
  );

  modport slave (
    input  mem_adr, ram_ce_n, ram_oe_n, ram_we_n, out_data, out_valid,
    output mem_db, out_ready
  );
endinterface

// File: rtl/sram_read_streamer.sv
// Sweeps an inclusive SRAM address range, samples each byte after a fixed access time
// and streams the bytes out through a small FIFO on a valid/ready interface.
module sram_read_streamer #(
  parameter int unsigned ADDR_W        = 19,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned FIFO_DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W-1:0]   last_addr,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     byte_count,
  sram_read_streamer_if.master bus
);

  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  WaitInit = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e            r_state;
  logic [ADDR_W-1:0] r_adr;
  logic [ADDR_W-1:0] r_last;
  logic [3:0]        r_wait;
  logic              r_strobe_n;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W:0]   r_byte_count;

  logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PtrW-1:0]   r_wptr;
  logic [PtrW-1:0]   r_rptr;
  logic [PtrW:0]     r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Flags come straight from the registered occupancy, so a same-cycle pop never frees a slot.
  assign w_full  = (r_count == (PtrW+1)'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && bus.out_ready;
  assign w_push  = (r_state == StRead) && (r_wait == 4'd0) && !w_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_adr        <= '0;
      r_last       <= '0;
      r_wait       <= 4'd0;
      r_strobe_n   <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_byte_count <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_pop) begin
        r_byte_count <= r_byte_count + (ADDR_W+1)'(1);
      end
      unique case (r_state)
        StIdle: begin
          // A start coinciding with the done pulse belongs to the finished sweep.
          if (start && !r_done) begin
            r_last       <= last_addr;
            r_adr        <= start_addr;
            r_strobe_n   <= 1'b0;
            r_busy       <= 1'b1;
            r_byte_count <= '0;
            r_wait       <= WaitInit;
            r_state      <= StRead;
          end
        end
        StRead: begin
          if (r_wait != 4'd0) begin
            r_wait <= r_wait - 4'd1;
          end else if (w_push) begin
            if (r_adr == r_last) begin
              r_strobe_n <= 1'b1;
              r_state    <= StDrain;
            end else begin
              r_adr  <= r_adr + ADDR_W'(1);
              r_wait <= WaitInit;
            end
          end
        end
        StDrain: begin
          if (w_empty) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= bus.mem_db;
        r_wptr         <= r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PtrW+1)'(1);
        2'b01:   r_count <= r_count - (PtrW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.mem_adr   = r_adr;
  assign bus.ram_ce_n  = r_strobe_n;
  assign bus.ram_oe_n  = r_strobe_n;
  assign bus.ram_we_n  = 1'b1;
  assign bus.out_data  = r_fifo[r_rptr];
  assign bus.out_valid = !w_empty;
  assign busy          = r_busy;
  assign done          = r_done;
  assign byte_count    = r_byte_count;

endmodule

// File: doc/sram_read_streamer.md
Name: sram_read_streamer

Overview:
Upstream feeder for the UART transmit path on the board's asynchronous 8-bit SRAM (19-bit address). It sweeps an inclusive address range and drives the SRAM control strobes, waiting a fixed access time before sampling each byte. Sampled bytes pass through a small FIFO and leave on a valid/ready byte stream that the UART byte sender consumes. SRAM access and UART transmission therefore overlap, and backpressure never corrupts a read.

Parameters:
ADDR_W, 19, SRAM address width; address arithmetic is modulo 2^ADDR_W
DATA_W, 8, SRAM data width and stream byte width
ACCESS_CYCLES, 2, clk edges from address change to data sample; legal range 1..15
FIFO_DEPTH, 2, output FIFO entries, power of two, at least 2

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  begin a sweep; sampled only in IDLE
start_addr  in  ADDR_W  first address, captured when start is accepted
last_addr  in  ADDR_W  final address (inclusive), captured when start is accepted
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse once the last byte has been popped from the FIFO
mem_adr  out  ADDR_W  SRAM address
mem_db  in  DATA_W  SRAM read data
ram_ce_n  out  1  chip enable, active-low
ram_oe_n  out  1  output enable, active-low
ram_we_n  out  1  write enable, active-low; constant 1
out_data  out  DATA_W  stream byte (FIFO head)
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts; a transfer occurs when out_valid and out_ready are both high
byte_count  out  ADDR_W+1  bytes popped since start acceptance

Behaviour:
- Reset values: state IDLE; mem_adr 0; ram_ce_n 1; ram_oe_n 1; ram_we_n 1; busy 0; done 0; out_valid 0; FIFO empty; byte_count 0; wait counter 0.
- A reset mid-sweep aborts immediately. The FIFO is flushed, no done pulse is issued, and all outputs return to reset values on the next edge.
- States: IDLE, READ, DRAIN.
- IDLE:
  - On an edge with start=1: latch last_addr; set mem_adr=start_addr; set ram_ce_n=ram_oe_n=0; set busy=1; clear byte_count; load wait_cnt=ACCESS_CYCLES-1; go to READ. Call this edge E0.
- READ:
  - While wait_cnt != 0, decrement it each edge.
  - When wait_cnt == 0 and the FIFO is not full, push mem_db on that edge.
    - If mem_adr == latched last_addr: set ram_ce_n=ram_oe_n=1 and go to DRAIN.
    - Otherwise: mem_adr <= mem_adr+1 mod 2^ADDR_W, and reload wait_cnt=ACCESS_CYCLES-1.
  - When wait_cnt == 0 and the FIFO is full: stall. mem_adr and the strobes hold, and mem_db is re-sampled at the edge where space exists.
  - Fullness for a push is judged on the registered full flag. No push occurs when full, even if a pop happens in the same cycle.
- DRAIN: when the FIFO is empty, pulse done=1 for one cycle, set busy=0, and go to IDLE.
- start is ignored while busy=1. A start in the same cycle as the done pulse is also ignored; it is accepted on the next edge.
- Latency:
  - The first byte is pushed at edge E0+ACCESS_CYCLES, so out_valid is visible after that edge.
  - With out_ready held at 1, the steady-state rate is one byte per ACCESS_CYCLES cycles.
  - done rises one edge after the final pop.
- Range rules:
  - start_addr == last_addr gives 1 byte.
  - last_addr < start_addr wraps through 2^ADDR_W-1 to 0.
  - The byte count is ((last_addr-start_addr) mod 2^ADDR_W)+1, so a full sweep is 524288 bytes with byte_count ending at 524288.
- Stream:
  - While out_valid=1 and out_ready=0, out_data must not change.
  - A pop and a push in the same cycle are legal when the FIFO is neither empty nor full (registered flags).
  - byte_count increments on each transfer.
- ram_we_n is never driven low. The block performs no SRAM writes.

Test Plan:
1. ACCESS_CYCLES=2, start_addr=last_addr=0x00010, SRAM model returns addr[7:0], out_ready=1.
   -> out_valid at E0+2 with out_data=0x10; exactly 1 transfer; done pulses once; byte_count=1; strobes are high after the capture.
2. Range 0x00000..0x00007, out_ready=1.
   -> bytes 0x00..0x07 in order; pushes spaced 2 cycles apart; byte_count=8; exactly one done pulse.
3. Same range with out_ready low for 20 cycles after the first byte.
   -> the FIFO fills, mem_adr holds at 0x00002 with strobes low, and out_data stays 0x00 stable; after release, all 8 bytes arrive with no loss or duplication.
4. start_addr=0x7FFFE, last_addr=0x00001.
   -> mem_adr sequence 7FFFE, 7FFFF, 00000, 00001; 4 bytes delivered; byte_count=4.
5. start pulsed again mid-sweep, and also in the done cycle.
   -> both ignored; a single sweep and a single done pulse.
6. rst asserted after 3 bytes, then a new start with range 0x00020..0x00021.
   -> outputs reach reset values one edge after rst with no done pulse; the new sweep delivers 0x20, 0x21; byte_count=2.
